// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: picks one of the ALU/LSU/MDU results per cycle and
// registers it onto the single register-file write port.
module wb_port_arbiter #(
    parameter int XLEN  = 32,
    parameter int RR_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            alu_ready,
    output logic            lsu_ready,
    output logic            mdu_ready,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [1:0]      wb_sel,
    output logic            conflict,
    output logic [1:0]      dbg_last_grant
);

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_LSU = 2'b01;
    localparam logic [1:0] SRC_MDU = 2'b10;

    // Handshake: a result moves when x_valid && x_ready in the same cycle; the
    // requester holds valid/rd/data stable until then, ready never depends on
    // anything but the current valids, last_grant and reset.
    logic [1:0]      last_grant;
    logic [2:0]      valid_vec;
    logic [2:0]      pick_res;
    logic            grant_any;
    logic [1:0]      grant_code;
    logic [4:0]      grant_rd;
    logic [XLEN-1:0] grant_data;

    assign valid_vec = {mdu_valid, lsu_valid, alu_valid};

    // Returns {found, code} for the first valid requester in order a, b, c.
    function automatic logic [2:0] pick(input logic [2:0] v, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] c);
        if (v[a])      return {1'b1, a};
        else if (v[b]) return {1'b1, b};
        else if (v[c]) return {1'b1, c};
        else           return 3'b000;
    endfunction

    always_comb begin
        pick_res = 3'b000;
        if (!reset) begin
            if (RR_EN != 0) begin
                case (last_grant)
                    SRC_ALU: pick_res = pick(valid_vec, SRC_LSU, SRC_MDU, SRC_ALU);
                    SRC_LSU: pick_res = pick(valid_vec, SRC_MDU, SRC_ALU, SRC_LSU);
                    default: pick_res = pick(valid_vec, SRC_ALU, SRC_LSU, SRC_MDU);
                endcase
            end else begin
                pick_res = pick(valid_vec, SRC_ALU, SRC_LSU, SRC_MDU);
            end
        end
    end

    assign grant_any  = pick_res[2];
    assign grant_code = pick_res[1:0];

    always_comb begin
        grant_rd   = alu_rd;
        grant_data = alu_data;
        case (grant_code)
            SRC_LSU: begin
                grant_rd   = lsu_rd;
                grant_data = lsu_data;
            end
            SRC_MDU: begin
                grant_rd   = mdu_rd;
                grant_data = mdu_data;
            end
            default: ;
        endcase
    end

    assign alu_ready = grant_any && (grant_code == SRC_ALU);
    assign lsu_ready = grant_any && (grant_code == SRC_LSU);
    assign mdu_ready = grant_any && (grant_code == SRC_MDU);

    assign conflict = !reset && ((alu_valid && lsu_valid) || (alu_valid && mdu_valid) ||
                                 (lsu_valid && mdu_valid));

    assign dbg_last_grant = last_grant;

    // last_grant resets to MDU so the round-robin search starts at ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= SRC_MDU;
            wb_en      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= '0;
            wb_sel     <= SRC_ALU;
        end else if (grant_any) begin
            last_grant <= grant_code;
            wb_en      <= (grant_rd != 5'd0);
            wb_rd      <= grant_rd;
            wb_data    <= grant_data;
            wb_sel     <= grant_code;
        end else begin
            wb_en      <= 1'b0;
        end
    end

endmodule
